lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 256 +++++++++++++++++++++++++
 tb/tb_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: 2 KiB word-addressed data memory plus memory-mapped
// LED/HEX output registers and synchronized switch/button inputs.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   addr              byte address (ALU result)
//   st_data           store data (rs2)
//   st_en, ld_en      store / load request this cycle
//   lsu_op            funct3 access type (B, H, W, BU, HU)
//   io_sw, io_btn     raw asynchronous switch / button inputs
//   ld_data           combinational load result
//   misalign          combinational misalignment flag
//   io_ledr/ledg/hex  peripheral output registers
module lsu #(
    parameter int DMEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic        st_en,
    input  logic        ld_en,
    input  logic [2:0]  lsu_op,
    input  logic [17:0] io_sw,
    input  logic [3:0]  io_btn,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic [17:0] io_ledr,
    output logic [7:0]  io_ledg,
    output logic [31:0] io_hex
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // Peripheral word addresses (byte address >> 2)
    localparam logic [29:0] WA_LEDR = 30'h0000_1C00;
    localparam logic [29:0] WA_LEDG = 30'h0000_1C04;
    localparam logic [29:0] WA_HEX  = 30'h0000_1C08;
    localparam logic [29:0] WA_SW   = 30'h0000_1E00;
    localparam logic [29:0] WA_BTN  = 30'h0000_1E04;

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    logic [31:0] mem_q [DMEM_WORDS];

    logic [17:0] ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;
    logic [31:0] hex_q,  hex_d;

    logic [17:0] sw_meta_q, sw_meta_d;
    logic [17:0] sw_sync_q, sw_sync_d;
    logic [3:0]  btn_meta_q, btn_meta_d;
    logic [3:0]  btn_sync_q, btn_sync_d;

    // ------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------
    logic [29:0]   waddr;
    logic [31:0]   widx;
    logic [AW-1:0] dmem_idx;
    logic          sel_dmem;
    logic          sel_ledr;
    logic          sel_ledg;
    logic          sel_hex;
    logic          sel_sw;
    logic          sel_btn;

    always_comb begin
        waddr    = addr[31:2];
        widx     = {2'b00, waddr};
        dmem_idx = addr[AW+1:2];
        sel_dmem = widx < 32'(DMEM_WORDS);
        sel_ledr = waddr == WA_LEDR;
        sel_ledg = waddr == WA_LEDG;
        sel_hex  = waddr == WA_HEX;
        sel_sw   = waddr == WA_SW;
        sel_btn  = waddr == WA_BTN;
    end

    // ------------------------------------------------------------
    // Alignment and op legality
    // ------------------------------------------------------------
    logic is_half;
    logic is_word;
    logic ld_legal;
    logic st_legal;

    always_comb begin
        is_half  = (lsu_op == OP_H) || (lsu_op == OP_HU);
        is_word  = lsu_op == OP_W;
        misalign = (is_half && addr[0]) ||
                   (is_word && (addr[1:0] != 2'b00));
        ld_legal = (lsu_op == OP_B)  || (lsu_op == OP_H) ||
                   (lsu_op == OP_W)  || (lsu_op == OP_BU) ||
                   (lsu_op == OP_HU);
        st_legal = (lsu_op == OP_B) || (lsu_op == OP_H) ||
                   (lsu_op == OP_W);
    end

    // ------------------------------------------------------------
    // Read path: select word, then extract lane
    // ------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            sel_dmem: rd_word = mem_q[dmem_idx];
            sel_ledr: rd_word = {14'b0, ledr_q};
            sel_ledg: rd_word = {24'b0, ledg_q};
            sel_hex:  rd_word = hex_q;
            sel_sw:   rd_word = {14'b0, sw_sync_q};
            sel_btn:  rd_word = {28'b0, btn_sync_q};
            default:  rd_word = '0;
        endcase
    end

    always_comb begin
        lane_b = rd_word[7:0];
        case (addr[1:0])
            2'd0:    lane_b = rd_word[7:0];
            2'd1:    lane_b = rd_word[15:8];
            2'd2:    lane_b = rd_word[23:16];
            default: lane_b = rd_word[31:24];
        endcase
        lane_h = addr[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        ld_data = '0;
        if (ld_en && !misalign && ld_legal) begin
            case (lsu_op)
                OP_B:    ld_data = {{24{lane_b[7]}}, lane_b};
                OP_BU:   ld_data = {24'b0, lane_b};
                OP_H:    ld_data = {{16{lane_h[15]}}, lane_h};
                OP_HU:   ld_data = {16'b0, lane_h};
                OP_W:    ld_data = rd_word;
                default: ld_data = '0;
            endcase
        end
    end

    // ------------------------------------------------------------
    // Write path: lane enables and replicated data
    // ------------------------------------------------------------
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        commit;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = st_data;
        case (lsu_op)
            OP_B: begin
                wr_be   = 4'b0001 << addr[1:0];
                wr_data = {4{st_data[7:0]}};
            end
            OP_H: begin
                wr_be   = addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{st_data[15:0]}};
            end
            OP_W: begin
                wr_be   = 4'b1111;
                wr_data = st_data;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = st_data;
            end
        endcase
        commit = st_en && !rst && st_legal && !misalign;
    end

    function automatic logic [31:0] merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    // Narrow registers are merged at 32 bits and truncated, so
    // unimplemented upper bits are simply dropped.
    logic [31:0] ledr_m;
    logic [31:0] ledg_m;

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        hex_d  = hex_q;
        ledr_m = merge({14'b0, ledr_q}, wr_data, wr_be);
        ledg_m = merge({24'b0, ledg_q}, wr_data, wr_be);
        if (commit && sel_ledr) ledr_d = ledr_m[17:0];
        if (commit && sel_ledg) ledg_d = ledg_m[7:0];
        if (commit && sel_hex)  hex_d  = merge(hex_q, wr_data, wr_be);
    end

    always_comb begin
        sw_meta_d  = io_sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = io_btn;
        btn_sync_d = btn_meta_q;
    end

    // ------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------
    // DMEM is deliberately not reset; commit already excludes rst.
    always_ff @(posedge clk) begin
        if (commit && sel_dmem) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[dmem_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hex_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hex_q      <= hex_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
        end
    end

    assign io_ledr = ledr_q;
    assign io_ledg = ledg_q;
    assign io_hex  = hex_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-level reference model predicts each
// cycle's load result, misalign flag and peripheral outputs.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        st_en;
    logic        ld_en;
    logic [2:0]  lsu_op;
    logic [17:0] io_sw;
    logic [3:0]  io_btn;
    logic [31:0] ld_data;
    logic        misalign;
    logic [17:0] io_ledr;
    logic [7:0]  io_ledg;
    logic [31:0] io_hex;

    always #5 clk = ~clk;

    lsu #(.DMEM_WORDS(512)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .st_data  (st_data),
        .st_en    (st_en),
        .ld_en    (ld_en),
        .lsu_op   (lsu_op),
        .io_sw    (io_sw),
        .io_btn   (io_btn),
        .ld_data  (ld_data),
        .misalign (misalign),
        .io_ledr  (io_ledr),
        .io_ledg  (io_ledg),
        .io_hex   (io_hex)
    );

    // Reference model state
    logic [7:0]  mb [2048];
    logic [31:0] m_ledr, m_ledg, m_hex;
    logic [17:0] m_sw_hist [2];
    logic [3:0]  m_bt_hist [2];
    bit          regs_known;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic [31:0] ledr;
        logic [31:0] ledg;
        logic [31:0] hex;
        bit          chk_io;
        int          id;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 0;

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFFC;
        if (b < 32'd2048) return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
        case (b)
            32'h7000: return m_ledr;
            32'h7010: return m_ledg;
            32'h7020: return m_hex;
            32'h7800: return {14'b0, m_sw_hist[1]};
            32'h7810: return {28'b0, m_bt_hist[1]};
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] op,
                                   input logic [31:0] a);
        if ((op == 3'd1 || op == 3'd5) && a[0]) return 1'b1;
        if (op == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic l,
                                           input logic [2:0] op,
                                           input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        if (!l || m_mis(op, a)) return 32'h0;
        w = m_word(a);
        b = 8'(w >> (8 * a[1:0]));
        h = 16'(w >> (16 * a[1]));
        case (op)
            3'd0: return 32'($signed(b));
            3'd4: return 32'(b);
            3'd1: return 32'($signed(h));
            3'd5: return 32'(h);
            3'd2: return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_store_byte(input logic [31:0] ba,
                                input logic [7:0] d);
        logic [31:0] w;
        if (ba < 32'd2048) begin
            mb[ba] = d;
        end else begin
            w = m_word(ba);
            w[8*ba[1:0] +: 8] = d;
            case (ba & 32'hFFFF_FFFC)
                32'h7000: m_ledr = w & 32'h0003_FFFF;
                32'h7010: m_ledg = w & 32'h0000_00FF;
                32'h7020: m_hex  = w;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s id=%0d got=%h exp=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty got=0 exp=1");
            end else begin
                e = sbq.pop_front();
                chk("ld_data", e.id, ld_data, e.ld);
                chk("misalign", e.id, 32'(misalign), 32'(e.mis));
                if (e.chk_io) begin
                    chk("io_ledr", e.id, 32'(io_ledr), e.ledr);
                    chk("io_ledg", e.id, 32'(io_ledg), e.ledg);
                    chk("io_hex", e.id, io_hex, e.hex);
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit s, input bit l,
                       input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input int id);
        exp_t e;
        int   n;
        rst     = r;
        st_en   = s;
        ld_en   = l;
        lsu_op  = op;
        addr    = a;
        st_data = d;
        e.ld     = m_load(l, op, a);
        e.mis    = m_mis(op, a);
        e.ledr   = m_ledr;
        e.ledg   = m_ledg;
        e.hex    = m_hex;
        e.chk_io = regs_known;
        e.id     = id;
        sbq.push_back(e);
        @(posedge clk);
        if (r) begin
            m_ledr = 0;
            m_ledg = 0;
            m_hex  = 0;
            m_sw_hist[0] = 0;
            m_sw_hist[1] = 0;
            m_bt_hist[0] = 0;
            m_bt_hist[1] = 0;
            regs_known = 1;
        end else begin
            if (s && op <= 3'd2 && !m_mis(op, a)) begin
                n = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
                for (int k = 0; k < n; k++)
                    m_store_byte(a + 32'(k), d[8*k +: 8]);
            end
            m_sw_hist[1] = m_sw_hist[0];
            m_sw_hist[0] = io_sw;
            m_bt_hist[1] = m_bt_hist[0];
            m_bt_hist[0] = io_btn;
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int          k;
        logic [31:0] base;
        k = $urandom_range(0, 9);
        if (k < 6) return 32'($urandom_range(0, 2047));
        if (k == 6) return 32'($urandom_range(32'h7FC, 32'h803));
        if (k < 9) begin
            case ($urandom_range(0, 4))
                0: base = 32'h7000;
                1: base = 32'h7010;
                2: base = 32'h7020;
                3: base = 32'h7800;
                default: base = 32'h7810;
            endcase
            return base + 32'($urandom_range(0, 3));
        end
        return $urandom;
    endfunction

    initial begin
        rst = 1; st_en = 0; ld_en = 0; lsu_op = 0;
        addr = 0; st_data = 0; io_sw = 0; io_btn = 0;
        m_ledr = 0; m_ledg = 0; m_hex = 0; regs_known = 0;
        m_sw_hist[0] = 0; m_sw_hist[1] = 0;
        m_bt_hist[0] = 0; m_bt_hist[1] = 0;
        for (int i = 0; i < 2048; i++) mb[i] = 8'h00;
        @(posedge clk);
        #1;
        mon_on = 1;
        cyc(1, 0, 0, 3'd2, 32'h0, 32'h0, 1);
        cyc(1, 0, 0, 3'd2, 32'h0, 32'h0, 2);
        for (int i = 0; i < 512; i++)
            cyc(0, 1, 0, 3'd2, 32'(i * 4), $urandom, 3);

        cyc(0, 1, 0, 3'd2, 32'h100, 32'h8000_00FF, 10);
        cyc(0, 0, 1, 3'd2, 32'h100, 32'h0, 11);
        cyc(0, 0, 1, 3'd0, 32'h103, 32'h0, 12);
        cyc(0, 0, 1, 3'd4, 32'h103, 32'h0, 13);
        cyc(0, 0, 1, 3'd1, 32'h102, 32'h0, 14);
        cyc(0, 0, 1, 3'd5, 32'h100, 32'h0, 15);

        cyc(0, 1, 0, 3'd2, 32'h200, 32'h0, 20);
        cyc(0, 1, 0, 3'd0, 32'h201, 32'hAB, 21);
        cyc(0, 0, 1, 3'd2, 32'h200, 32'h0, 22);
        cyc(0, 1, 0, 3'd1, 32'h202, 32'h1234, 23);
        cyc(0, 0, 1, 3'd2, 32'h200, 32'h0, 24);

        cyc(0, 1, 0, 3'd2, 32'h102, 32'hDEAD_BEEF, 30);
        cyc(0, 0, 1, 3'd2, 32'h100, 32'h0, 31);
        cyc(0, 0, 1, 3'd1, 32'h101, 32'h0, 32);

        cyc(0, 1, 0, 3'd2, 32'h7000, 32'hFFFF_FFFF, 40);
        cyc(0, 0, 1, 3'd2, 32'h7000, 32'h0, 41);
        cyc(1, 1, 1, 3'd2, 32'h7000, 32'h1234_5678, 42);
        cyc(0, 0, 1, 3'd2, 32'h100, 32'h0, 43);
        cyc(0, 0, 1, 3'd2, 32'h7000, 32'h0, 44);

        io_sw = 18'h2AAAA;
        io_btn = 4'hA;
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 3'd2, 32'h7800, 32'h0, 50 + i);
        cyc(0, 0, 1, 3'd2, 32'h7810, 32'h0, 54);
        cyc(0, 1, 0, 3'd2, 32'h7800, 32'h0, 55);
        cyc(0, 0, 1, 3'd2, 32'h7800, 32'h0, 56);

        cyc(0, 1, 0, 3'd2, 32'h300, 32'h0, 60);
        cyc(0, 1, 1, 3'd0, 32'h300, 32'h55, 61);
        cyc(0, 0, 1, 3'd2, 32'h300, 32'h0, 62);
        cyc(0, 0, 1, 3'd2, 32'h1000, 32'h0, 63);

        cyc(0, 1, 0, 3'd2, 32'h7010, 32'hCAFE_F00D, 70);
        cyc(0, 1, 0, 3'd1, 32'h7022, 32'hBEEF, 71);
        cyc(0, 0, 1, 3'd2, 32'h7010, 32'h0, 72);
        cyc(0, 0, 1, 3'd2, 32'h7020, 32'h0, 73);
        cyc(0, 1, 0, 3'd3, 32'h7020, 32'hFFFF_FFFF, 74);
        cyc(0, 0, 1, 3'd6, 32'h7020, 32'h0, 75);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) io_sw = 18'($urandom);
            if ($urandom_range(0, 7) == 0) io_btn = 4'($urandom);
            cyc(($urandom_range(0, 49) == 0), 1'($urandom),
                1'($urandom), 3'($urandom), rnd_addr(),
                $urandom, 1000 + i);
        end

        mon_on = 0;
        chk("sb_drain", 0, 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
